// File: rtl/cia_pkg.sv
// Shared definitions for the pipelined carry-increment adder.
// Holds the default block width, the segment-width helper and the
// parameter legality check used at elaboration time.
package cia_pkg;

    localparam int CIA_BLK_DEFAULT = 4;

    // Width of one pipeline segment for a WIDTH-bit add split over STAGES.
    function automatic int cia_seg_width(input int w, input int s);
        return (s > 0) ? (w / s) : w;
    endfunction

    // True when the WIDTH/BLK/STAGES combination can be built.
    function automatic bit cia_params_ok(input int w, input int b, input int s);
        return (b > 0) && (s >= 1) && (s <= w / b) && ((w % (s * b)) == 0);
    endfunction

endpackage

// File: rtl/cia_segment.sv
// Combinational carry-increment segment.
// Each BLK-bit block computes x+y and x+y+1 up front; the incoming carry
// only selects between them, so the carry chain is one mux per block.
module cia_segment #(
    parameter int SEG = 16,
    parameter int BLK = 4
) (
    input  logic [SEG-1:0] a_s,
    input  logic [SEG-1:0] b_s,
    input  logic           ci,
    output logic [SEG-1:0] s_s,
    output logic           co
);

    localparam int NB = SEG / BLK;

    logic [NB:0] c;

    assign c[0] = ci;
    assign co   = c[NB];

    for (genvar j = 0; j < NB; j++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;

        // Both candidate sums, independent of the block carry-in.
        assign s0 = {1'b0, a_s[j*BLK +: BLK]} + {1'b0, b_s[j*BLK +: BLK]};
        assign s1 = {1'b0, a_s[j*BLK +: BLK]} + {1'b0, b_s[j*BLK +: BLK]}
                    + {{BLK{1'b0}}, 1'b1};

        // Carry-in picks the sum bits and the carry handed to the next block.
        assign s_s[j*BLK +: BLK] = c[j] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[j+1]            = c[j] ? s1[BLK]     : s0[BLK];
    end

endmodule

// File: rtl/pipelined_carry_increment_adder.sv
// Pipelined carry-increment adder: sum = a + b + cin, one segment per stage.
// Optional macro CIA_OVERFLOW_EN adds a registered signed-overflow flag.
//
// Handshake: a request transfers on a rising edge when in_valid && in_ready;
// a result transfers when out_valid && out_ready. The whole pipe advances
// together (adv = !out_valid || out_ready) and in_ready = adv, so a stalled
// result holds every stage. Data may change only after it has transferred.
module pipelined_carry_increment_adder
    import cia_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int BLK    = CIA_BLK_DEFAULT,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = cia_seg_width(WIDTH, STAGES);

    if (!cia_params_ok(WIDTH, BLK, STAGES)) begin : g_param_check
        $error("pipelined_carry_increment_adder: WIDTH must be a multiple of STAGES*BLK and 1 <= STAGES <= WIDTH/BLK");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * SEG;  // sum bits finished after this stage
        localparam int HW = WIDTH - SW;     // operand bits still waiting upstream of their stage

        logic [SEG-1:0] a_seg;
        logic [SEG-1:0] b_seg;
        logic [SEG-1:0] s_seg;
        logic           ci;
        logic           co;
        logic           v_in;
        logic           v_q;
        logic           c_q;
        logic [SW-1:0]  s_q;

        if (k == 0) begin : g_src
            assign a_seg = a[SEG-1:0];
            assign b_seg = b[SEG-1:0];
            assign ci    = cin;
            assign v_in  = in_valid;

            // First sum segment enters the deskew chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (adv) begin
                    s_q <= s_seg;
                end
            end
        end else begin : g_src
            assign a_seg = g_stage[k-1].g_skew.a_q[SEG-1:0];
            assign b_seg = g_stage[k-1].g_skew.b_q[SEG-1:0];
            assign ci    = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;

            // Append this segment above the lower segments already summed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (adv) begin
                    s_q <= {s_seg, g_stage[k-1].s_q};
                end
            end
        end

        cia_segment #(
            .SEG (SEG),
            .BLK (BLK)
        ) u_seg (
            .a_s (a_seg),
            .b_s (b_seg),
            .ci  (ci),
            .s_s (s_seg),
            .co  (co)
        );

        // Valid bit and inter-segment carry move one stage per advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= co;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;
            logic [HW-1:0] a_nx;
            logic [HW-1:0] b_nx;

            if (k == 0) begin : g_nx
                assign a_nx = a[WIDTH-1:SEG];
                assign b_nx = b[WIDTH-1:SEG];
            end else begin : g_nx
                assign a_nx = g_stage[k-1].g_skew.a_q[HW+SEG-1:SEG];
                assign b_nx = g_stage[k-1].g_skew.b_q[HW+SEG-1:SEG];
            end

            // Upper operand segments wait here until their stage comes up.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

`ifdef CIA_OVERFLOW_EN
    // The operand sign bits reach the last stage through the skew chain.
    logic a_msb;
    logic b_msb;
    logic s_msb;
    logic ovf_q;

    assign a_msb = g_stage[STAGES-1].a_seg[SEG-1];
    assign b_msb = g_stage[STAGES-1].b_seg[SEG-1];
    assign s_msb = g_stage[STAGES-1].s_seg[SEG-1];

    // Overflow is registered with the final sum segment and shares its stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (a_msb == b_msb) && (s_msb != a_msb);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Testbench for pipelined_carry_increment_adder (WIDTH=64, BLK=4, STAGES=4).
// Expected results come from plain wide-integer arithmetic on each accepted
// request, held in an in-order queue.
module tb_pipelined_carry_increment_adder;

  localparam int WIDTH  = 64;
  localparam int BLK    = 4;
  localparam int STAGES = 4;
  localparam int RW     = WIDTH + 2;  // {ovf, cout, sum}

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  logic [RW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipelined_carry_increment_adder #(
    .WIDTH  (WIDTH),
    .BLK    (BLK),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic c);
    logic [WIDTH:0] t;
    logic           v;
    t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    v = 1'b0;
`ifdef CIA_OVERFLOW_EN
    v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
`endif
    return {v, t};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: w = '1;
      1: w[31:0] = 32'hFFFF_FFFF;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Apply one cycle of inputs, let them settle, record an accepted request.
  task automatic step(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic c, input logic r);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = r;
    #1;
    if (v && in_ready) exp_q.push_back(model(x, y, c));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input string nm, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic c, input logic [WIDTH-1:0] es, input logic ec,
                             input logic eo);
    int seen;
    int count;
    logic eo_m;
    seen  = -1;
    count = 0;
    eo_m  = 1'b0;
`ifdef CIA_OVERFLOW_EN
    eo_m  = eo;
`endif
    for (int cyc = 0; cyc <= STAGES + 3; cyc++) begin
      step(cyc == 0, x, y, c, 1'b1);
      if (out_valid === 1'b1) begin
        count++;
        if (seen < 0) seen = cyc;
        n_cmp++; if (sum !== es) begin n_fail++; $display("FAIL %s_sum got=%h exp=%h", nm, sum, es); end
        n_cmp++; if (cout !== ec) begin n_fail++; $display("FAIL %s_cout got=%b exp=%b", nm, cout, ec); end
        n_cmp++; if (ovf !== eo_m) begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", nm, ovf, eo_m); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
    n_cmp++; if (seen != STAGES) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, seen, STAGES); end
    n_cmp++; if (count != 1) begin n_fail++; $display("FAIL %s_count got=%0d exp=1", nm, count); end
    exp_q.delete();
  endtask

  task automatic test_streaming();
    int got;
    logic ev;
    logic [RW-1:0] e;
    logic [RW-1:0] obs;
    got = 0;
    for (int cyc = 0; cyc < 16 + STAGES + 3; cyc++) begin
      step(cyc < 16, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b1);
      ev = (cyc >= STAGES) && (cyc < STAGES + 16);
      n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev); end
      if (out_valid === 1'b1) begin
        got++;
        obs = {ovf, cout, sum};
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++; $display("FAIL stream_extra got=%h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL stream_data got=%h exp=%h", obs, e); end
        end
      end
      tick();
    end
    n_cmp++; if (got != 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", got); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back_backpressure();
    logic [WIDTH-1:0] xa, xb;
    logic xc, xv, r, prev_stall;
    logic [RW-1:0] obs, prev_obs, e;
    int sent, got;
    xa = '0; xb = '0; xc = 1'b0; xv = 1'b0;
    prev_stall = 1'b0; prev_obs = '0;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 150 && got < 8; cyc++) begin
      if (!xv && sent < 8 && $urandom_range(0, 3) != 0) begin
        xv = 1'b1; xa = rand_word(); xb = rand_word(); xc = 1'($urandom_range(0, 1));
      end
      r = (cyc % 3 == 0);
      step(xv, xa, xb, xc, r);
      obs = {ovf, cout, sum};
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, obs, prev_obs);
        end
      end
      if (out_valid === 1'b1 && !r) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall got=%b exp=0", in_ready); end
      end
      if (r) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_free got=%b exp=1", in_ready); end
      end
      if (out_valid === 1'b1 && r) begin
        got++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++; $display("FAIL bp_extra got=%h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL bp_data got=%h exp=%h", obs, e); end
        end
      end
      if (xv && in_ready) begin xv = 1'b0; sent++; end
      prev_stall = (out_valid === 1'b1) && !r;
      prev_obs   = obs;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 8) begin n_fail++; $display("FAIL bp_count got=%0d exp=8", got); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic [RW-1:0] e;
    for (int cyc = 0; cyc < 3; cyc++) begin
      step(1'b1, rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b1);
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++; if ({ovf, cout, sum} !== e) begin n_fail++; $display("FAIL mid_data got=%h exp=%h", {ovf, cout, sum}, e); end
      end
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_fail++; $display("FAIL mid_reset_sum got=%h exp=0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cout got=%b exp=0", cout); end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < STAGES + 3; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", cyc, out_valid); end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single("cross_seg", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0);
    test_single("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                64'h0, 1'b1, 1'b0);
    test_single("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);
    test_single("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0, 1'b1, 1'b1);
    test_streaming();
    test_back_to_back_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
